// File: rtl/apu_pkg.sv
// Shared APU timing constants and frame sequencer types.
// Used by the frame counter and by the DMC/noise timing logic.
package apu_pkg;

    typedef enum logic {
        FRAME_4STEP = 1'b0,
        FRAME_5STEP = 1'b1
    } frame_mode_t;

    localparam int CNT_W = 16;

    // CPU-cycle positions of the sequencer steps within one frame
    localparam logic [CNT_W-1:0] Q1_CYC  = 16'd7457;
    localparam logic [CNT_W-1:0] Q2_CYC  = 16'd14913;
    localparam logic [CNT_W-1:0] Q3_CYC  = 16'd22371;
    localparam logic [CNT_W-1:0] Q4_CYC4 = 16'd29829;
    localparam logic [CNT_W-1:0] Q4_CYC5 = 16'd37281;
    localparam logic [CNT_W-1:0] IRQ_PRE_CYC = Q4_CYC4 - 16'd1;

    // $4017 write-to-reset latency, chosen by CPU cycle parity at the write
    localparam int              WR_DLY_W      = 3;
    localparam logic [WR_DLY_W-1:0] WR_DELAY_EVEN = 3'd3;
    localparam logic [WR_DLY_W-1:0] WR_DELAY_ODD  = 3'd4;

endpackage

// File: rtl/frame_write_delay.sv
// CPU cycle parity and the delayed sequencer reset that follows a $4017 write.
// seq_reset is high in the last cycle of the countdown; cyc clears on the following edge.
module frame_write_delay
    import apu_pkg::*;
(
    input  logic cpu_clk,
    input  logic rst,
    input  logic reg_write,
    output logic seq_reset
);

    logic                parity;
    logic [WR_DLY_W-1:0] cnt;

    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            parity <= 1'b0;
            cnt    <= '0;
        end else begin
            parity <= ~parity;
            if (reg_write)
                cnt <= parity ? WR_DELAY_ODD : WR_DELAY_EVEN;
            else if (cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end

    // A write landing on the expiry cycle restarts the delay instead of firing
    assign seq_reset = (cnt == 3'd1) && !reg_write;

endmodule

// File: rtl/apu_frame_counter.sv
// NES APU frame sequencer ($4017): quarter/half-frame pulses and frame IRQ.
// Define APU_FRAME_IRQ_EN to build the IRQ flag; otherwise frame_irq is tied 0.
module apu_frame_counter
    import apu_pkg::*;
(
    input  logic       cpu_clk,
    input  logic       rst,
    input  logic       reg_write,
    input  logic [7:0] reg_wdata,
    input  logic       status_read,
    output logic       quarter_frame,
    output logic       half_frame,
    output logic       frame_irq,
    output logic       mode_5step
);

    frame_mode_t      mode;
    logic [CNT_W-1:0] cyc;
    logic [CNT_W-1:0] last_cyc;
    logic             seq_reset;
    logic             q_hit;
    logic             h_hit;
    logic             forced;

    frame_write_delay u_wr_delay (
        .cpu_clk   (cpu_clk),
        .rst       (rst),
        .reg_write (reg_write),
        .seq_reset (seq_reset)
    );

    assign last_cyc   = (mode == FRAME_5STEP) ? Q4_CYC5 : Q4_CYC4;
    assign mode_5step = (mode == FRAME_5STEP);
    assign forced     = seq_reset && (mode == FRAME_5STEP);

    always_comb begin
        q_hit = (cyc == Q1_CYC) || (cyc == Q2_CYC) || (cyc == Q3_CYC) || (cyc == last_cyc);
        h_hit = (cyc == Q2_CYC) || (cyc == last_cyc);
    end

    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            mode          <= FRAME_4STEP;
            cyc           <= '0;
            quarter_frame <= 1'b0;
            half_frame    <= 1'b0;
        end else begin
            if (reg_write)
                mode <= frame_mode_t'(reg_wdata[7]);
            // >= also recovers if a mode switch leaves cyc beyond the 4-step end
            if (seq_reset || cyc >= last_cyc)
                cyc <= '0;
            else
                cyc <= cyc + 1'b1;
            quarter_frame <= q_hit || forced;
            half_frame    <= h_hit || forced;
        end
    end

    logic unused_wdata;
    assign unused_wdata = ^reg_wdata[5:0];

`ifdef APU_FRAME_IRQ_EN
    logic inhibit;
    logic wrapped;
    logic irq_set;

    // A write selecting 5-step blocks a set on its own edge as well
    assign irq_set = (mode == FRAME_4STEP) && !(reg_write && reg_wdata[7]) &&
                     ((cyc == IRQ_PRE_CYC) || (cyc == Q4_CYC4) || ((cyc == '0) && wrapped));

    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            inhibit   <= 1'b0;
            wrapped   <= 1'b0;
            frame_irq <= 1'b0;
        end else begin
            if (reg_write)
                inhibit <= reg_wdata[6];
            // Only a natural wrap arms the cyc==0 set; a write-reset does not
            wrapped <= (mode == FRAME_4STEP) && (cyc == Q4_CYC4) && !seq_reset;
            if (inhibit)
                frame_irq <= 1'b0;
            else if (irq_set)
                frame_irq <= 1'b1;
            else if (status_read)
                frame_irq <= 1'b0;
        end
    end
`else
    logic unused_irq_inputs;
    assign unused_irq_inputs = status_read ^ reg_wdata[6];
    assign frame_irq = 1'b0;
`endif

endmodule

// File: tb/tb_apu_frame_counter.sv
// Directed bench for apu_frame_counter; k counts cpu_clk edges since the last reset release.
// IRQ expectations follow APU_FRAME_IRQ_EN the same way the design does.
module tb_apu_frame_counter;

    logic       cpu_clk = 1'b0;
    logic       rst = 1'b1;
    logic       reg_write = 1'b0;
    logic [7:0] reg_wdata = 8'h00;
    logic       status_read = 1'b0;
    logic       quarter_frame, half_frame, frame_irq, mode_5step;

    int n_chk = 0;
    int n_err = 0;
    int k = 0;

    apu_frame_counter dut (
        .cpu_clk       (cpu_clk),
        .rst           (rst),
        .reg_write     (reg_write),
        .reg_wdata     (reg_wdata),
        .status_read   (status_read),
        .quarter_frame (quarter_frame),
        .half_frame    (half_frame),
        .frame_irq     (frame_irq),
        .mode_5step    (mode_5step)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (k=%0d)", tag, got, exp, k);
        end
    endtask

    task automatic step();
        @(posedge cpu_clk);
        #1;
        k++;
    endtask

    task automatic wr(input logic [7:0] d);
        reg_write = 1'b1;
        reg_wdata = d;
        step();
        reg_write = 1'b0;
        reg_wdata = 8'h00;
    endtask

    // Run n cycles; pulses expected only at the listed k (-1 = unused), IRQ high
    // for k in [irq_lo, irq_hi], status_read driven during cycles sra/srb.
    task automatic scan(input string tag, input int n,
                        input int qa, input int qb, input int qc, input int qd,
                        input int ha, input int hb,
                        input int irq_lo, input int irq_hi,
                        input int sra, input int srb);
        int  qerr, herr, ierr, qcnt;
        bit  eq, eh, ei;
        qerr = 0; herr = 0; ierr = 0; qcnt = 0;
        for (int i = 0; i < n; i++) begin
            status_read = (k == sra) || (k == srb);
            step();
            status_read = 1'b0;
            eq = (k == qa) || (k == qb) || (k == qc) || (k == qd);
            eh = (k == ha) || (k == hb);
`ifdef APU_FRAME_IRQ_EN
            ei = (k >= irq_lo) && (k <= irq_hi);
`else
            ei = 1'b0;
`endif
            if (quarter_frame !== eq) qerr++;
            if (half_frame !== eh)    herr++;
            if (frame_irq !== ei)     ierr++;
            if (quarter_frame === 1'b1) qcnt++;
        end
        chk({tag, "_qf_miss"}, qerr, 0);
        chk({tag, "_hf_miss"}, herr, 0);
        chk({tag, "_irq_miss"}, ierr, 0);
        chk({tag, "_qf_count"}, qcnt,
            ((qa > 0) ? 1 : 0) + ((qb > 0) ? 1 : 0) + ((qc > 0) ? 1 : 0) + ((qd > 0) ? 1 : 0));
    endtask

    initial begin
        repeat (2) @(posedge cpu_clk);
        #1;
        chk("rst_qf", quarter_frame, 0);
        chk("rst_hf", half_frame, 0);
        chk("rst_irq", frame_irq, 0);
        chk("rst_mode", mode_5step, 0);
        rst = 1'b0;
        k = 0;

        // Full 4-step frame; status_read on the Q4 set cycle, then after the wrap
        scan("a4", 29834, 7458, 14914, 22372, 29830, 14914, 29830,
             29829, 29832, 29829, 29832);

        // 0x80 at even parity: cyc clears at edge 29838, forced pulse then
        wr(8'h80);
        chk("b_mode", mode_5step, 1);
        scan("b5", 37300 - 29835, 29838, 37296, -1, -1, 29838, -1, -1, -2, -1, -1);

        // 0x00 at odd parity, then 0x40 two cycles later restarts: reset at 37308, not 37306
        scan("c_pre", 1, -1, -1, -1, -1, -1, -1, -1, -2, -1, -1);
        wr(8'h00);
        chk("c_mode", mode_5step, 0);
        scan("c_gap", 1, -1, -1, -1, -1, -1, -1, -1, -2, -1, -1);
        wr(8'h40);
        scan("c4", 44770 - 37304, 44766, -1, -1, -1, -1, -1, -1, -2, -1, -1);

        // Run to cyc 20000, write 5-step, then reset while the write is pending
        scan("d4", 57308 - 44770, 52222, -1, -1, -1, 52222, -1, -1, -2, -1, -1);
        wr(8'h80);
        chk("d_mode", mode_5step, 1);
        #2 rst = 1'b1;
        #1;
        chk("d_rst_qf", quarter_frame, 0);
        chk("d_rst_hf", half_frame, 0);
        chk("d_rst_irq", frame_irq, 0);
        chk("d_rst_mode", mode_5step, 0);
        @(posedge cpu_clk);
        #1;
        rst = 1'b0;
        k = 0;
        scan("r4", 7460, 7458, -1, -1, -1, -1, -1, -1, -2, -1, -1);
        chk("r_mode", mode_5step, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
